// File: rtl/compound_out_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | compound_out_arbiter                                                        |
// | Two-requester round-robin arbiter onto one blocking CompoundType channel,   |
// | with a non-blocking monitor copy. Optional COMPOUND_ARB_WRITE_PRIO_EN lets  |
// | a lone write request beat the round-robin pointer.                          |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+

package compound_types_pkg;
  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } mode_t;

  typedef struct packed {
    mode_t              mode;
    logic signed [31:0] x;
    logic               y;
  } compound_t;

  typedef enum logic [0:0] {
    SECTION_A = 1'b0,
    SECTION_B = 1'b1
  } section_t;

  localparam compound_t C_IDLE_MSG = '{mode: READ, x: 32'sd0, y: 1'b0};
endpackage

module compound_out_arbiter
  import compound_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  compound_t        req0_in,
  input  logic             req0_in_sync,
  output logic             req0_in_notify,
  input  compound_t        req1_in,
  input  logic             req1_in_sync,
  output logic             req1_in_notify,
  output compound_t        b_out,
  input  logic             b_out_sync,
  output logic             b_out_notify,
  output compound_t        m_out,
  output logic             m_out_notify,
  output logic             grant_id,
  output logic             busy,
  output logic [CNT_W-1:0] msg_count
);

  section_t         section_q;
  logic             ptr_q;
  compound_t        b_out_q;
  compound_t        m_out_q;
  logic             b_notify_q;
  logic             m_notify_q;
  logic             req0_notify_q;
  logic             req1_notify_q;
  logic             grant_id_q;
  logic             busy_q;
  logic [CNT_W-1:0] msg_count_q;

  logic             grant_vld_d;
  logic             grant_idx_d;
  compound_t        grant_msg_d;

  always_comb begin
    grant_vld_d = req0_in_sync | req1_in_sync;
    if (req0_in_sync && req1_in_sync) begin
`ifdef COMPOUND_ARB_WRITE_PRIO_EN
      // Exactly one write among two contenders overrides the pointer.
      if (req0_in.mode != req1_in.mode) begin
        grant_idx_d = (req1_in.mode == WRITE);
      end else begin
        grant_idx_d = ptr_q;
      end
`else
      grant_idx_d = ptr_q;
`endif
    end else begin
      grant_idx_d = req1_in_sync;
    end
    grant_msg_d = grant_idx_d ? req1_in : req0_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      section_q     <= SECTION_A;
      ptr_q         <= 1'b0;
      b_out_q       <= C_IDLE_MSG;
      m_out_q       <= C_IDLE_MSG;
      b_notify_q    <= 1'b0;
      m_notify_q    <= 1'b0;
      req0_notify_q <= 1'b0;
      req1_notify_q <= 1'b0;
      grant_id_q    <= 1'b0;
      busy_q        <= 1'b0;
      msg_count_q   <= '0;
    end else begin
      case (section_q)
        SECTION_A: begin
          if (grant_vld_d) begin
            b_out_q       <= grant_msg_d;
            m_out_q       <= grant_msg_d;
            b_notify_q    <= 1'b1;
            m_notify_q    <= 1'b1;
            req0_notify_q <= ~grant_idx_d;
            req1_notify_q <= grant_idx_d;
            grant_id_q    <= grant_idx_d;
            busy_q        <= 1'b1;
            section_q     <= SECTION_B;
          end
        end
        SECTION_B: begin
          // Acks and monitor pulse last exactly one cycle regardless of the consumer.
          req0_notify_q <= 1'b0;
          req1_notify_q <= 1'b0;
          m_notify_q    <= 1'b0;
          if (b_out_sync) begin
            b_notify_q  <= 1'b0;
            busy_q      <= 1'b0;
            msg_count_q <= msg_count_q + CNT_W'(1);
            ptr_q       <= ~grant_id_q;
            section_q   <= SECTION_A;
          end
        end
        default: section_q <= SECTION_A;
      endcase
    end
  end

  assign req0_in_notify = req0_notify_q;
  assign req1_in_notify = req1_notify_q;
  assign b_out          = b_out_q;
  assign b_out_notify   = b_notify_q;
  assign m_out          = m_out_q;
  assign m_out_notify   = m_notify_q;
  assign grant_id       = grant_id_q;
  assign busy           = busy_q;
  assign msg_count      = msg_count_q;

endmodule
`default_nettype wire

// File: tb/tb_compound_out_arbiter.sv
`default_nettype none
// tb_compound_out_arbiter: directed self-checking bench; a second 3-bit-counter
// instance runs in lockstep so the counter wrap is reached in few cycles.
module tb_compound_out_arbiter;
  import compound_types_pkg::*;

  logic        clk;
  logic        rst;
  compound_t   req0_in, req1_in;
  logic        req0_in_sync, req1_in_sync, b_out_sync;
  logic        req0_in_notify, req1_in_notify;
  compound_t   b_out, m_out;
  logic        b_out_notify, m_out_notify, grant_id, busy;
  logic [15:0] msg_count;

  logic        s_req0_notify, s_req1_notify, s_b_notify, s_m_notify, s_grant, s_busy;
  compound_t   s_b_out, s_m_out;
  logic [2:0]  s_msg_count;

  int          n_checks;
  int          n_pass;
  logic [15:0] exp_cnt;
  compound_t   m0, m1, e;

  compound_out_arbiter #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_in(req0_in), .req0_in_sync(req0_in_sync), .req0_in_notify(req0_in_notify),
    .req1_in(req1_in), .req1_in_sync(req1_in_sync), .req1_in_notify(req1_in_notify),
    .b_out(b_out), .b_out_sync(b_out_sync), .b_out_notify(b_out_notify),
    .m_out(m_out), .m_out_notify(m_out_notify),
    .grant_id(grant_id), .busy(busy), .msg_count(msg_count)
  );

  compound_out_arbiter #(.CNT_W(3)) dut_w3 (
    .clk(clk), .rst(rst),
    .req0_in(req0_in), .req0_in_sync(req0_in_sync), .req0_in_notify(s_req0_notify),
    .req1_in(req1_in), .req1_in_sync(req1_in_sync), .req1_in_notify(s_req1_notify),
    .b_out(s_b_out), .b_out_sync(b_out_sync), .b_out_notify(s_b_notify),
    .m_out(s_m_out), .m_out_notify(s_m_notify),
    .grant_id(s_grant), .busy(s_busy), .msg_count(s_msg_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_cnt(input string tag);
    check({tag, "_count"}, 64'(msg_count), 64'(exp_cnt));
    check({tag, "_count_w3"}, 64'(s_msg_count), 64'(exp_cnt[2:0]));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_b_out"}, 64'(b_out), 64'(C_IDLE_MSG));
    check({tag, "_m_out"}, 64'(m_out), 64'(C_IDLE_MSG));
    check({tag, "_notifies"},
          64'({req0_in_notify, req1_in_notify, b_out_notify, m_out_notify}), 64'(0));
    check({tag, "_grant_busy"}, 64'({grant_id, busy}), 64'(0));
    check_cnt(tag);
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    exp_cnt      = 16'd0;
    rst          = 1'b1;
    req0_in      = C_IDLE_MSG;
    req1_in      = C_IDLE_MSG;
    req0_in_sync = 1'b0;
    req1_in_sync = 1'b0;
    b_out_sync   = 1'b0;
    #2 rst = 1'b0;
    step();
    step();
    check_idle("reset");
    rst = 1'b1;
    step();

    // Single request from requester 1
    e = '{mode: WRITE, x: 32'sd5, y: 1'b1};
    req1_in      = e;
    req1_in_sync = 1'b1;
    step();
    check("single_b_out", 64'(b_out), 64'(e));
    check("single_m_out", 64'(m_out), 64'(e));
    check("single_notifies",
          64'({req0_in_notify, req1_in_notify, b_out_notify, m_out_notify}), 64'(4'b0111));
    check("single_grant_busy", 64'({grant_id, busy}), 64'(2'b11));
    req1_in_sync = 1'b0;
    step();
    check("single_pulse_clear",
          64'({req1_in_notify, m_out_notify, b_out_notify}), 64'(3'b001));
    b_out_sync = 1'b1;
    step();
    exp_cnt = 16'd1;
    check("single_xfer", 64'({b_out_notify, busy}), 64'(0));
    check_cnt("single");
    b_out_sync = 1'b0;

    // Continuous traffic from both, consumer always ready
    m0 = '{mode: READ, x: 32'sh11, y: 1'b0};
    m1 = '{mode: READ, x: -32'sd7, y: 1'b1};
    req0_in      = m0;
    req1_in      = m1;
    req0_in_sync = 1'b1;
    req1_in_sync = 1'b1;
    b_out_sync   = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("rr_grant", 64'(grant_id), 64'(k % 2));
      check("rr_b_out", 64'(b_out), (k % 2 == 0) ? 64'(m0) : 64'(m1));
      check("rr_acks", 64'({req0_in_notify, req1_in_notify, b_out_notify}),
            (k % 2 == 0) ? 64'(3'b101) : 64'(3'b011));
      step();
      exp_cnt = exp_cnt + 16'd1;
      check("rr_xfer", 64'(b_out_notify), 64'(0));
    end
    check_cnt("rr");
    req0_in_sync = 1'b0;
    req1_in_sync = 1'b0;
    b_out_sync   = 1'b0;

    // Consumer stalls five cycles; requester 1 waits meanwhile
    e = '{mode: WRITE, x: 32'sh1234, y: 1'b1};
    req0_in      = e;
    req0_in_sync = 1'b1;
    step();
    check("stall_grant", 64'(grant_id), 64'(0));
    req0_in_sync = 1'b0;
    req1_in_sync = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("stall_b_out", 64'(b_out), 64'(e));
      check("stall_hold", 64'({b_out_notify, busy, req1_in_notify}), 64'(3'b110));
    end
    b_out_sync = 1'b1;
    step();
    exp_cnt = 16'd8;
    check("stall_xfer", 64'(b_out_notify), 64'(0));
    check_cnt("stall_wrap");
    step();
    check("after_stall_grant", 64'({grant_id, req1_in_notify}), 64'(2'b11));
    req1_in_sync = 1'b0;
    step();
    exp_cnt = 16'd9;
    check_cnt("after_stall");

    // Leave the pointer at 1, then reset mid-transfer
    req0_in_sync = 1'b1;
    step();
    req0_in_sync = 1'b0;
    step();
    exp_cnt = 16'd10;
    check_cnt("pre_reset");
    b_out_sync   = 1'b0;
    req1_in_sync = 1'b1;
    step();
    check("pre_reset_busy", 64'({grant_id, busy}), 64'(2'b11));
    req1_in_sync = 1'b0;
    #2 rst = 1'b0;
    #1;
    exp_cnt = 16'd0;
    check_idle("async_reset");
    #1 rst = 1'b1;
    req0_in      = m0;
    req1_in      = m1;
    req0_in_sync = 1'b1;
    req1_in_sync = 1'b1;
    b_out_sync   = 1'b1;
    step();
    check("post_reset_grant", 64'({grant_id, req0_in_notify, req1_in_notify}), 64'(3'b010));
    check("post_reset_b_out", 64'(b_out), 64'(m0));
    req0_in_sync = 1'b0;
    req1_in_sync = 1'b0;
    step();
    exp_cnt = 16'd1;
    check_cnt("post_reset");

    // Return pointer to 0, then read vs write contention
    req1_in_sync = 1'b1;
    step();
    req1_in_sync = 1'b0;
    step();
    exp_cnt = 16'd2;
    check_cnt("prio_prep");
    e = '{mode: WRITE, x: 32'sd77, y: 1'b0};
    req0_in      = m0;
    req1_in      = e;
    req0_in_sync = 1'b1;
    req1_in_sync = 1'b1;
    step();
`ifdef COMPOUND_ARB_WRITE_PRIO_EN
    check("prio_grant", 64'({grant_id, req0_in_notify, req1_in_notify}), 64'(3'b101));
    check("prio_b_out", 64'(b_out), 64'(e));
`else
    check("prio_grant", 64'({grant_id, req0_in_notify, req1_in_notify}), 64'(3'b010));
    check("prio_b_out", 64'(b_out), 64'(m0));
`endif
    req0_in_sync = 1'b0;
    req1_in_sync = 1'b0;
    step();
    exp_cnt = 16'd3;
    check_cnt("prio");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
